uart_div_sched: RTL and testbench
=================================

Name: uart_div_sched

Overview:
Command scheduler between the UART byte receiver/transmitter and a shared iterative 16-bit divider.
- Assembles 4-byte request frames from the RX byte stream.
- Issues one divide per frame over a start/done handshake, handling divide-by-zero without the divider.
- Serialises quotient and remainder back to the UART TX over a start/busy handshake.
- Drops bytes arriving while busy, and abandons partial frames after an inter-byte timeout.

Parameters:
DW, 16, operand/result width; frame fixed at 2 bytes per operand (DW=16 only supported).
TIMEOUT, 50000, idle clk cycles after which a partial frame is discarded (1 ms at 50 MHz).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
rx_valid  input  1  one-cycle pulse, rx_data valid.
rx_data  input  8  received byte.
div_start  output  1  one-cycle pulse, launch divide.
div_a  output  DW  dividend, stable from div_start until div_done.
div_b  output  DW  divisor, stable from div_start until div_done.
div_busy  input  1  divider occupied.
div_done  input  1  one-cycle pulse, div_q/div_r valid.
div_q  input  DW  quotient.
div_r  input  DW  remainder.
tx_start  output  1  one-cycle pulse, transmit tx_data.
tx_data  output  8  byte to send, held until next tx_start.
tx_busy  input  1  transmitter active; rises at most 1 cycle after tx_start.
result_led  output  24  [15:0]=last quotient, [16]=last frame div-by-zero, [17]=sticky timeout seen, [23:18]=0.
ovf_cnt  output  8  saturating count of dropped rx bytes.
busy  output  1  high in any state other than RX.

Behaviour:
- Reset (rst low, async): state=RX, byte index=0, timeout counter=0, all outputs 0.
- Frame format: byte order a[7:0], a[15:8], b[7:0], b[15:8] (little-endian).
- RX state, on rx_valid:
  - store the byte at the current index, index++, clear timeout counter.
  - if this was the 4th byte: index←0, next state DIV_REQ.
- Timeout (RX only):
  - with index≠0 and no rx_valid, the counter increments each cycle.
  - when it reaches TIMEOUT-1: index←0, counter←0, result_led[17]←1.
  - rx_valid on the same cycle wins; no timeout is taken.
- DIV_REQ:
  - if b==0: q←16'hFFFF, r←a, result_led[16]←1, no div_start issued, next state TX_SEND.
  - else if !div_busy: div_start=1 for one cycle, result_led[16]←0, next state DIV_WAIT.
  - else wait in DIV_REQ.
- DIV_WAIT: on div_done, capture div_q/div_r, result_led[15:0]←div_q, next state TX_SEND. No timeout while waiting.
- Transmit sequence: q[7:0], q[15:8], r[7:0], r[15:8] (tx index 0..3).
- TX_SEND: when !tx_busy, drive tx_data with byte[tx index], pulse tx_start one cycle, next state TX_GUARD.
- TX_GUARD: one cycle unconditionally, covers tx_busy rise latency; next state TX_WAIT.
- TX_WAIT: when tx_busy low:
  - last byte: tx index←0, next state RX.
  - otherwise: tx index++, next state TX_SEND.
- Dropped bytes: rx_valid in any state except RX is discarded; ovf_cnt++ saturating at 255. Never affects the frame in progress.
- Latency, frame to divider: last rx_valid → div_start = 2 cycles when div_busy is low.
- Latency, divider to TX: div_done → first tx_start = 2 cycles when tx_busy is low.
- Reset mid-operation: everything returns to reset values. An in-flight divide result arriving later is ignored (div_done outside DIV_WAIT has no effect).
- div_a/div_b are registered from the frame; they change only when the 4th byte is captured.

Optional Feature:
STATUS_BYTE_EN
- Defined: a status byte is prepended to each response, making it 5 bytes.
  - Status 8'hA5 = normal; 8'hEE = divide-by-zero.
  - Bit 0 of the status byte is XORed with result_led[17] (timeout seen): 8'hA4 / 8'hEF when set.
  - tx index runs 0..4.
- Undefined: 4-byte response exactly as above; no status logic synthesised.

Test Plan:
1. Normal divide: rx E8 03 07 00 (a=1000, b=7); model divider returns q=142, r=6 after 16 cycles. Required: div_a=1000, div_b=7, exactly one div_start; tx bytes 8E 00 06 00; result_led=0x00008E.
2. Divide-by-zero: rx 34 12 00 00. Required: no div_start; tx FF FF 34 12; result_led[16]=1, [15:0]=FFFF.
3. Timeout: rx 11 22, idle TIMEOUT cycles, then rx 10 00 03 00. Required: result_led[17]=1; divide uses a=16, b=3; tx 05 00 01 00.
4. Overrun: send 3 extra rx bytes during TX_WAIT of test 1. Required: ovf_cnt=3; tx stream unchanged; next 4-byte frame processes normally. Also drive 300 drops and check ovf_cnt=255.
5. Backpressure and reset: hold div_busy=1 for 50 cycles in DIV_REQ; start must wait. Assert rst low during the 2nd tx byte. Required: all outputs 0 immediately; a stray div_done afterwards causes no tx; next frame processed normally.
6. With STATUS_BYTE_EN, repeat test 1 then test 2. Required: tx A5 8E 00 06 00, then EE FF FF 34 12.

Source files
------------

// File: rtl/uart_div_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_div_sched_if
// Description : RX byte, divider and TX handshake bundle for uart_div_sched.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_div_sched_if #(
  parameter int DW = 16
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          div_start;
  logic [DW-1:0] div_a;
  logic [DW-1:0] div_b;
  logic          div_busy;
  logic          div_done;
  logic [DW-1:0] div_q;
  logic [DW-1:0] div_r;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic [23:0]   result_led;
  logic [7:0]    ovf_cnt;
  logic          busy;

  modport master (
    input  rx_valid, rx_data, div_busy, div_done, div_q, div_r, tx_busy,
    output div_start, div_a, div_b, tx_start, tx_data, result_led, ovf_cnt, busy
  );

  modport slave (
    output rx_valid, rx_data, div_busy, div_done, div_q, div_r, tx_busy,
    input  div_start, div_a, div_b, tx_start, tx_data, result_led, ovf_cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_div_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_div_sched
// Description : Frames UART RX bytes into divide requests, drives a shared
//               divider and serialises quotient/remainder to UART TX.
//               Optional macro STATUS_BYTE_EN prepends a status byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_div_sched #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 50000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_div_sched_if.master bus
);

  localparam int c_TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TW-1:0] c_TO_MAX = c_TW'(TIMEOUT - 1);
`ifdef STATUS_BYTE_EN
  localparam logic [2:0] c_TX_LAST = 3'd4;
  localparam logic [7:0] c_ST_OK   = 8'hA5;
  localparam logic [7:0] c_ST_DZ   = 8'hEE;
`else
  localparam logic [2:0] c_TX_LAST = 3'd3;
`endif

  typedef enum logic [2:0] {
    S_RX       = 3'd0,
    S_DIV_REQ  = 3'd1,
    S_DIV_WAIT = 3'd2,
    S_TX_SEND  = 3'd3,
    S_TX_GUARD = 3'd4,
    S_TX_WAIT  = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_rx_idx;
  logic [c_TW-1:0] r_to_cnt;
  logic [7:0]      r_a_lo;
  logic [7:0]      r_a_hi;
  logic [7:0]      r_b_lo;
  logic [DW-1:0]   r_div_a;
  logic [DW-1:0]   r_div_b;
  logic            r_div_start;
  logic [DW-1:0]   r_q;
  logic [DW-1:0]   r_r;
  logic [2:0]      r_tx_idx;
  logic            r_tx_start;
  logic [7:0]      r_tx_data;
  logic [15:0]     r_led_q;
  logic            r_dz;
  logic            r_sticky;
  logic [7:0]      r_ovf;

  logic w_rx_take, w_to_abort, w_to_inc, w_div_go, w_dz_go, w_done_take;
  logic w_tx_go, w_tx_adv, w_tx_end, w_drop;
  logic [7:0] w_tx_byte;

  always_comb begin
    w_state_nxt = r_state;
    w_rx_take   = 1'b0;
    w_to_abort  = 1'b0;
    w_to_inc    = 1'b0;
    w_div_go    = 1'b0;
    w_dz_go     = 1'b0;
    w_done_take = 1'b0;
    w_tx_go     = 1'b0;
    w_tx_adv    = 1'b0;
    w_tx_end    = 1'b0;
    case (r_state)
      S_RX: begin
        // a byte arriving on the timeout cycle keeps the frame alive
        if (bus.rx_valid) begin
          w_rx_take = 1'b1;
          if (r_rx_idx == 2'd3) w_state_nxt = S_DIV_REQ;
        end else if (r_rx_idx != 2'd0) begin
          if (r_to_cnt == c_TO_MAX) w_to_abort = 1'b1;
          else                      w_to_inc   = 1'b1;
        end
      end
      S_DIV_REQ: begin
        if (r_div_b == '0) begin
          w_dz_go     = 1'b1;
          w_state_nxt = S_TX_SEND;
        end else if (!bus.div_busy) begin
          w_div_go    = 1'b1;
          w_state_nxt = S_DIV_WAIT;
        end
      end
      S_DIV_WAIT: begin
        if (bus.div_done) begin
          w_done_take = 1'b1;
          w_state_nxt = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        if (!bus.tx_busy) begin
          w_tx_go     = 1'b1;
          w_state_nxt = S_TX_GUARD;
        end
      end
      S_TX_GUARD: w_state_nxt = S_TX_WAIT;
      S_TX_WAIT: begin
        if (!bus.tx_busy) begin
          if (r_tx_idx == c_TX_LAST) begin
            w_tx_end    = 1'b1;
            w_state_nxt = S_RX;
          end else begin
            w_tx_adv    = 1'b1;
            w_state_nxt = S_TX_SEND;
          end
        end
      end
      default: w_state_nxt = S_RX;
    endcase
  end

  assign w_drop = bus.rx_valid && (r_state != S_RX);

`ifdef STATUS_BYTE_EN
  logic [7:0] w_status;
  assign w_status = (r_dz ? c_ST_DZ : c_ST_OK) ^ {7'b0, r_sticky};
`endif

  always_comb begin
    w_tx_byte = 8'h00;
    case (r_tx_idx)
`ifdef STATUS_BYTE_EN
      3'd0:    w_tx_byte = w_status;
      3'd1:    w_tx_byte = r_q[7:0];
      3'd2:    w_tx_byte = r_q[15:8];
      3'd3:    w_tx_byte = r_r[7:0];
      3'd4:    w_tx_byte = r_r[15:8];
`else
      3'd0:    w_tx_byte = r_q[7:0];
      3'd1:    w_tx_byte = r_q[15:8];
      3'd2:    w_tx_byte = r_r[7:0];
      3'd3:    w_tx_byte = r_r[15:8];
`endif
      default: w_tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RX;
      r_rx_idx    <= 2'd0;
      r_to_cnt    <= '0;
      r_a_lo      <= 8'h00;
      r_a_hi      <= 8'h00;
      r_b_lo      <= 8'h00;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_div_start <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_tx_idx    <= 3'd0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_led_q     <= 16'h0000;
      r_dz        <= 1'b0;
      r_sticky    <= 1'b0;
      r_ovf       <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_div_start <= w_div_go;
      r_tx_start  <= w_tx_go;

      if (w_rx_take) begin
        r_to_cnt <= '0;
        r_rx_idx <= r_rx_idx + 2'd1;
        case (r_rx_idx)
          2'd0:    r_a_lo <= bus.rx_data;
          2'd1:    r_a_hi <= bus.rx_data;
          2'd2:    r_b_lo <= bus.rx_data;
          default: begin
            // operands only move once the whole frame is in
            r_div_a <= {r_a_hi, r_a_lo};
            r_div_b <= {bus.rx_data, r_b_lo};
          end
        endcase
      end else if (w_to_abort) begin
        r_rx_idx <= 2'd0;
        r_to_cnt <= '0;
        r_sticky <= 1'b1;
      end else if (w_to_inc) begin
        r_to_cnt <= r_to_cnt + c_TW'(1);
      end

      if (w_dz_go) begin
        r_q     <= '1;
        r_r     <= r_div_a;
        r_led_q <= 16'hFFFF;
        r_dz    <= 1'b1;
      end
      if (w_div_go) r_dz <= 1'b0;
      if (w_done_take) begin
        r_q     <= bus.div_q;
        r_r     <= bus.div_r;
        r_led_q <= bus.div_q;
      end

      if (w_tx_go)  r_tx_data <= w_tx_byte;
      if (w_tx_adv) r_tx_idx  <= r_tx_idx + 3'd1;
      if (w_tx_end) r_tx_idx  <= 3'd0;

      if (w_drop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;
    end
  end

  assign bus.div_start  = r_div_start;
  assign bus.div_a      = r_div_a;
  assign bus.div_b      = r_div_b;
  assign bus.tx_start   = r_tx_start;
  assign bus.tx_data    = r_tx_data;
  assign bus.result_led = {6'b0, r_sticky, r_dz, r_led_q};
  assign bus.ovf_cnt    = r_ovf;
  assign bus.busy       = (r_state != S_RX);

endmodule
`default_nettype wire

// File: tb/tb_uart_div_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_div_sched
// Description : Scoreboard bench for uart_div_sched with divider/TX models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_div_sched;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_div_sched_if #(.DW(16)) bus();
  uart_div_sched #(.DW(16), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        hold = 1'b0, stray_done = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [15:0] m_q = 16'h0, m_r = 16'h0, dv_a = 16'h0, dv_b = 16'h0;
  logic        tx_busy_m = 1'b0;

  assign bus.rx_valid = rx_valid;
  assign bus.rx_data  = rx_data;
  assign bus.div_busy = m_busy | hold;
  assign bus.div_done = m_done | stray_done;
  assign bus.div_q    = m_q;
  assign bus.div_r    = m_r;
  assign bus.tx_busy  = tx_busy_m;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_div[$];
  logic [31:0] e_div;
  logic [7:0]  e_tx;
  int n_tx = 0, n_ds = 0, dv_cnt = 0, txc = 0;
  int done_cyc = 0, last_rx_cyc = 0;
  bit lat_pending = 1'b0, chk_ds_lat = 1'b0, sticky_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // divider model: 16-cycle busy window, then a one-cycle done pulse
  always @(negedge clk) begin
    m_done = 1'b0;
    if (bus.div_start) begin
      n_ds++;
      if (exp_div.size() == 0) check("div_start_unexpected", 32'd1, 32'd0);
      else begin
        e_div = exp_div.pop_front();
        check("div_ab", {bus.div_a, bus.div_b}, e_div);
      end
      if (chk_ds_lat) check("div_start_latency", 32'(cyc - last_rx_cyc), 32'd2);
      dv_a = bus.div_a; dv_b = bus.div_b; m_busy = 1'b1; dv_cnt = 16;
    end else if (m_busy) begin
      dv_cnt--;
      if (dv_cnt == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_q = dv_a / dv_b; m_r = dv_a % dv_b;
        done_cyc = cyc; lat_pending = 1'b1;
      end
    end
  end

  // transmitter model: busy rises with tx_start and stays up for 3 cycles
  always @(negedge clk) begin
    if (bus.tx_start) begin
      n_tx++;
      if (exp_tx.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
      else begin
        e_tx = exp_tx.pop_front();
        check("tx_byte", {24'h0, bus.tx_data}, {24'h0, e_tx});
      end
      if (lat_pending) begin
        check("tx_latency", 32'(cyc - done_cyc), 32'd2);
        lat_pending = 1'b0;
      end
      tx_busy_m = 1'b1; txc = 3;
    end else if (txc > 0) begin
      txc--;
      if (txc == 0) tx_busy_m = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit rec);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    if (rec) last_rx_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input int gap,
                            output logic [31:0] led);
    logic [15:0] q, r;
    logic [7:0]  st;
    bit dz;
    dz = (b == 16'h0);
    if (dz) begin q = 16'hFFFF; r = a; end
    else begin q = a / b; r = a % b; exp_div.push_back({a, b}); end
`ifdef STATUS_BYTE_EN
    st = (dz ? 8'hEE : 8'hA5) ^ {7'b0, sticky_m};
    exp_tx.push_back(st);
`else
    st = 8'h00;
`endif
    exp_tx.push_back(q[7:0]); exp_tx.push_back(q[15:8]);
    exp_tx.push_back(r[7:0]); exp_tx.push_back(r[15:8]);
    led = {8'h0, 6'b0, sticky_m, dz, q};
    chk_ds_lat = !hold;
    send_byte(a[7:0], 1'b1);  tick(gap);
    send_byte(a[15:8], 1'b1); tick(gap);
    send_byte(b[7:0], 1'b1);  tick(gap);
    send_byte(b[15:8], 1'b1);
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!bus.busy && exp_tx.size() == 0 && txc == 0) break;
    end
    if (k == 3000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_tx(input int target);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (n_tx >= target) break;
    end
    if (k == 3000) check("tx_wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {29'h0, bus.div_start, bus.tx_start, bus.busy}, 32'd0);
    check({tag, "_ab"}, {bus.div_a, bus.div_b}, 32'd0);
    check({tag, "_data"}, {16'h0, bus.tx_data, bus.ovf_cnt}, 32'd0);
    check({tag, "_led"}, {8'h0, bus.result_led}, 32'd0);
  endtask

  initial begin
    logic [31:0] led;
    int ds0, tx0;
    tick(3);
    check_zero("reset");
    rst = 1'b1;
    tick(2);

    // normal divide, with three overrun bytes during the response
    ds0 = n_ds; tx0 = n_tx;
    send_frame(16'd1000, 16'd7, 0, led);
    wait_tx(tx0 + 1);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    wait_idle();
    check("t1_one_start", 32'(n_ds - ds0), 32'd1);
    check("t1_led", {8'h0, bus.result_led}, led);
    check("t1_led_abs", {8'h0, bus.result_led}, 32'h0000008E);
    check("t1_ovf", {24'h0, bus.ovf_cnt}, 32'd3);
    check("t1_ab_hold", {bus.div_a, bus.div_b}, {16'd1000, 16'd7});

    // divide by zero bypasses the divider
    ds0 = n_ds;
    send_frame(16'h1234, 16'h0000, 0, led);
    wait_idle();
    check("t2_no_start", 32'(n_ds - ds0), 32'd0);
    check("t2_led", {8'h0, bus.result_led}, 32'h0001FFFF);

    // partial frame abandoned after the idle timeout
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    tick(TO + 5);
    sticky_m = 1'b1;
    check("t3_sticky", {31'h0, bus.result_led[17]}, 32'd1);
    send_frame(16'd16, 16'd3, 0, led);
    wait_idle();
    check("t3_led", {8'h0, bus.result_led}, 32'h00020005);

    // inter-byte gaps just under the timeout keep the frame intact
    send_frame(16'd7, 16'd7, TO - 20, led);
    wait_idle();
    check("gap_led", {8'h0, bus.result_led}, led);

    // divider backpressure, overrun saturation, then reset mid-transmit
    ds0 = n_ds;
    hold = 1'b1;
    send_frame(16'd100, 16'd10, 0, led);
    tick(50);
    check("bp_no_start", 32'(n_ds - ds0), 32'd0);
    check("bp_busy", {31'h0, bus.busy}, 32'd1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'(i);
    end
    @(negedge clk); rx_valid = 1'b0;
    check("ovf_sat", {24'h0, bus.ovf_cnt}, 32'd255);
    tx0 = n_tx;
    hold = 1'b0;
    wait_tx(tx0 + 2);
    check("bp_one_start", 32'(n_ds - ds0), 32'd1);
    #1 rst = 1'b0;
    #1 check_zero("midrst");
    exp_tx.delete();
    sticky_m = 1'b0;
    check("midrst_div_q", 32'(exp_div.size()), 32'd0);
    tick(2);
    rst = 1'b1;
    tx0 = n_tx;
    @(negedge clk); stray_done = 1'b1;
    @(negedge clk); stray_done = 1'b0;
    tick(20);
    check("stray_no_tx", 32'(n_tx - tx0), 32'd0);
    check("stray_idle", {31'h0, bus.busy}, 32'd0);
    send_frame(16'd50000, 16'd300, 0, led);
    wait_idle();
    check("post_led", {8'h0, bus.result_led}, 32'h000000A6);
    check("post_ovf", {24'h0, bus.ovf_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
